// File: rtl/video_timing_pkg.sv
// Shared raster timing: default 640x480 constants, total helpers, frame FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package video_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int CW_DEF       = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } state_e;

  function automatic int h_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int v_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// h/v raster counters with registered vs/hs/de and x/y decode.
// Latency: outputs reflect the counter value of the previous cycle (1 clock).
// Backpressure: none; counts freely while run_i, holds at 0 otherwise.
module video_timing_cnt
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          run_i,
  output logic [CW-1:0] h_o,
  output logic [CW-1:0] v_o,
  output logic          vs_o,
  output logic          hs_o,
  output logic          de_o,
  output logic [CW-1:0] x_o,
  output logic [CW-1:0] y_o
);

  localparam int HT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CW-1:0] H_LAST = CW'(HT - 1);
  localparam logic [CW-1:0] V_LAST = CW'(VT - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic [CW-1:0] x_q, y_q;
  logic          de_q, hs_q, vs_q;
  logic          de_c, hs_c, vs_c;

  // Next counter values and combinational decode of the current position.
  always_comb begin
    h_d = '0;
    v_d = '0;
    if (run_i) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
        v_d = v_q;
      end
    end
    de_c = run_i && (h_q < H_ACT) && (v_q < V_ACT);
    hs_c = run_i && (h_q >= HS_BEG) && (h_q < HS_END);
    vs_c = run_i && (v_q >= VS_BEG) && (v_q < VS_END);
  end

  // Counter state and registered sync/de/coordinate outputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      h_q  <= '0;
      v_q  <= '0;
      de_q <= 1'b0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      x_q  <= '0;
      y_q  <= '0;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      de_q <= de_c;
      hs_q <= hs_c;
      vs_q <= vs_c;
      x_q  <= de_c ? h_q : '0;
      y_q  <= de_c ? v_q : '0;
    end
  end

  assign h_o  = h_q;
  assign v_o  = v_q;
  assign de_o = de_q;
  assign hs_o = hs_q;
  assign vs_o = vs_q;
  assign x_o  = x_q;
  assign y_o  = y_q;

endmodule

// File: rtl/video_frame_ctrl.sv
// Frame sequencer: single/continuous frames, graceful stop, returned-pixel accounting.
// Latency: start at edge N -> first de_out/x=0/y=0 after edge N+1; frame_done 1 clock after last return.
// Backpressure: none; downstream must return every pixel within the vertical blanking.
module video_frame_ctrl
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          start,
  input  logic          cont_en,
  input  logic          stop,
  output logic          busy,
  output logic          vs_out,
  output logic          hs_out,
  output logic          de_out,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  input  logic          de_ret,
  output logic          frame_done,
  output logic          pix_err
);

  localparam int HT       = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VT       = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int NPIX     = H_ACTIVE * V_ACTIVE;
  localparam int RCW      = $clog2(NPIX + 1);
  localparam int IDLE_LIM = V_BP * HT;
  localparam int ICW      = $clog2(IDLE_LIM + 2);

  localparam logic [CW-1:0]  H_LAST  = CW'(HT - 1);
  localparam logic [CW-1:0]  V_LAST  = CW'(VT - 1);
  localparam logic [RCW-1:0] RC_FULL = RCW'(NPIX);
  localparam logic [RCW-1:0] RC_PEN  = RCW'(NPIX - 1);
  localparam logic [ICW-1:0] IDLE_TH = ICW'(IDLE_LIM);
  localparam logic [ICW-1:0] IDLE_SAT = ICW'(IDLE_LIM + 1);

  state_e         state_q;
  logic           busy_q;
  logic [CW-1:0]  h, v;
  logic           frame_last, frame_first, start_acc;
  logic [RCW-1:0] rc_q, rc_d;
  logic [ICW-1:0] idle_q, idle_d;
  logic           rc_clr, rc_full, done_d, err_set;
  logic           done_q, err_q;

  video_timing_cnt #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CW(CW)
  ) u_cnt (
    .clk   (clk),
    .rst_b (rst_b),
    .run_i (busy_q),
    .h_o   (h),
    .v_o   (v),
    .vs_o  (vs_out),
    .hs_o  (hs_out),
    .de_o  (de_out),
    .x_o   (x),
    .y_o   (y)
  );

  assign frame_last  = busy_q && (h == H_LAST) && (v == V_LAST);
  assign frame_first = busy_q && (h == '0) && (v == '0);
  assign start_acc   = (state_q == IDLE) && start;

  // Frame sequencing; a stop in the frame's last cycle drops straight to IDLE.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (frame_last) begin
            if (!cont_en || stop) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else if (stop) begin
            state_q <= LAST;
          end
        end
        LAST: begin
          if (frame_last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Return accounting and error detection for the next cycle.
  always_comb begin
    rc_clr  = start_acc || frame_first;
    rc_full = (rc_q == RC_FULL);
    rc_d    = rc_q;
    if (rc_clr) begin
      rc_d = '0;
    end else if (de_ret && !rc_full) begin
      rc_d = rc_q + 1'b1;
    end
    done_d = !rc_clr && de_ret && (rc_q == RC_PEN);
    idle_d = idle_q;
    if (busy_q) begin
      idle_d = '0;
    end else if (idle_q != IDLE_SAT) begin
      idle_d = idle_q + 1'b1;
    end
    // Late IDLE returns are ones that cannot belong to the frame just finished.
    err_set = (de_ret && rc_full)
           || (!busy_q && de_ret && (idle_q > IDLE_TH))
           || (frame_last && (rc_d != RC_FULL));
  end

  // Return counter, idle timer, frame_done pulse and sticky error.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rc_q   <= '0;
      idle_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      rc_q   <= rc_d;
      idle_q <= idle_d;
      done_q <= done_d;
      if (start_acc) begin
        err_q <= 1'b0;
      end else if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  assign busy       = busy_q;
  assign frame_done = done_q;
  assign pix_err    = err_q;

endmodule

// File: doc/video_frame_ctrl.md
Name: video_frame_ctrl

Overview:
- Frame sequencer and sync generator that drives vs/hs/de plus pixel coordinates into the RGB-to-YCbCr and downstream filter pipeline.
- Software starts a single frame or continuous frames and can request a stop; the block finishes the current frame first.
- It counts the pixels returned at the end of the pipeline, pulses frame_done when a frame has fully emerged, and flags a sticky error on any count mismatch.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch in clocks
- H_SYNC, 96, hs pulse width in clocks
- H_BP, 48, horizontal back porch in clocks
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vs pulse width in lines
- V_BP, 33, vertical back porch in lines
- CW, 12, width of the h/v counters and of x/y; must satisfy 2^CW >= max(H_TOTAL, V_TOTAL)

Ports:
- clk, in, 1, pixel clock
- rst_b, in, 1, asynchronous active-low reset
- start, in, 1, one-cycle pulse; honoured only in IDLE
- cont_en, in, 1, 1 = continuous frames; sampled at each frame's last cycle
- stop, in, 1, one-cycle pulse; finish the current frame, then go idle
- busy, out, 1, high in RUN and LAST
- vs_out, out, 1, vertical sync, active high
- hs_out, out, 1, horizontal sync, active high
- de_out, out, 1, data enable; pixel fetch request to the source
- x, out, CW, pixel column; valid when de_out=1, otherwise 0
- y, out, CW, pixel line; valid when de_out=1, otherwise 0
- de_ret, in, 1, de as returned at the end of the processing pipeline
- frame_done, out, 1, one-cycle pulse when H_ACTIVE*V_ACTIVE pixels have returned
- pix_err, out, 1, sticky error flag; cleared by an accepted start

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Reset: state=IDLE; all counters 0; every output 0.
- Counters h and v:
  - h counts 0..H_TOTAL-1 and wraps to 0.
  - v increments when h wraps, counting 0..V_TOTAL-1.
  - Both hold at 0 in IDLE.
- Decode (all outputs registered; they reflect the current h/v):
  - de_out = (h < H_ACTIVE) && (v < V_ACTIVE)
  - hs_out = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
  - vs_out = V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC
  - x = h and y = v while de_out=1, otherwise 0
- Latency: start sampled at edge N gives de_out=1 with x=0, y=0 after edge N+1.
- State machine:
  - IDLE: start=1 moves to RUN and clears pix_err and the return counter.
  - RUN, last cycle of the frame (h=H_TOTAL-1, v=V_TOTAL-1):
    - cont_en=1 and no stop pending: wrap to h=0, v=0 and stay in RUN with no gap cycle.
    - otherwise: go to IDLE.
  - RUN, stop=1 in any cycle: go to LAST.
  - LAST: behaves exactly like RUN; at the frame's last cycle, go to IDLE regardless of cont_en.
  - start is ignored in RUN and LAST. stop is ignored in IDLE and LAST.
  - If stop arrives in the frame's last cycle, the block goes straight to IDLE.
- Return counter rc (width ceil(log2(H_ACTIVE*V_ACTIVE+1))):
  - Cleared in the first cycle of every frame (h=0, v=0 while busy).
  - Increments on each de_ret=1.
  - frame_done pulses in the cycle after rc reaches H_ACTIVE*V_ACTIVE.
- pix_err is set by any of:
  - de_ret=1 when rc already equals H_ACTIVE*V_ACTIVE
  - de_ret=1 while in IDLE, more than V_BP*H_TOTAL cycles after leaving busy
  - a frame wrap (or the end of the last frame) with rc < H_ACTIVE*V_ACTIVE
- Constraint: pipeline latency must be less than (V_TOTAL-V_ACTIVE)*H_TOTAL, so every frame's returns complete within its vertical blanking.
- Asynchronous reset mid-frame: all outputs drop to 0 immediately; there is no partial frame_done.

Decomposition:
- Shared package video_timing_pkg holds:
  - the default 640x480 timing constants
  - the H_TOTAL/V_TOTAL helper functions
  - the state enum (IDLE, RUN, LAST)
- One natural sub-module, video_timing_cnt: the h/v counter pair plus sync/de decode with registered outputs.
- video_frame_ctrl itself holds the FSM, the return counter and the error logic.

Test Plan:
All scenarios use small timing: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1 (H_TOTAL=8); V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=6). One frame is 48 cycles with 12 active pixels.
- Single frame: start pulse with cont_en=0 and de_ret = de_out delayed 5 cycles -> 12 de_out cycles with x 0..3 and y 0..2; hs high at h=5 and h=6 on every line; vs high for 8 cycles at v=4; frame_done pulses once; busy falls after 48 cycles; pix_err=0.
- Continuous with stop: cont_en=1, start, then stop during frame 2 -> frames 1-2 are back-to-back with no gap cycle; frame 3 never starts; two frame_done pulses.
- Missing return: drop one de_ret in frame 1 -> rc=11 at the wrap, pix_err=1, no frame_done pulse; the next accepted start clears pix_err.
- Extra return: 13 de_ret pulses in one frame -> pix_err=1 on the 13th pulse.
- Ignored inputs: start pulsed in RUN and stop pulsed in IDLE -> no change in timing or state.
- Reset mid-frame: rst_b low at h=2, v=1 -> vs/hs/de/x/y/busy are 0 immediately; after release the block is idle until the next start.
